// File: rtl/bcd_seg_scan_driver.sv
// Multiplexed common-segment 7-segment driver for a packed BCD word.
// A word is loaded through a valid/ready handshake into a pending buffer.
// The pending word moves to the active buffer only on a frame boundary, so
// one frame never shows digits from two different words. The active word is
// scanned one digit per refresh slot, with optional leading-zero blanking.
// A sticky flag reports any nibble above 9 in the active word.
module bcd_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    output logic                      ready,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      blank,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      bcd_err
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Active-low segment pattern (a..g on bits 6..0); codes above 9 go dark.
    function automatic logic [6:0] bcd_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // True when any nibble of the word is not a legal BCD digit.
    function automatic logic word_has_illegal(input logic [DW-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            bad = bad | (w[4*j +: 4] > 4'd9);
        end
        return bad;
    endfunction

    logic [PW-1:0]         presc_r;
    logic [IW-1:0]         idx_r;
    logic [DW-1:0]         active_r;
    logic [DW-1:0]         pending_r;
    logic                  pend_flag_r;
    logic                  ready_r;
    logic                  bcd_err_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;

    logic                  presc_tc_s;
    logic                  frame_end_s;
    logic                  accept_s;
    logic                  transfer_s;
    logic [3:0]            nibble_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic                  nz_above_s;
    logic                  lz_blank_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;
    logic [6:0]            seg_nxt_s;

    assign presc_tc_s  = (presc_r == PRESC_LAST);
    assign frame_end_s = presc_tc_s && (idx_r == IDX_LAST);
    assign accept_s    = load && ready_r;
    // A transfer and an accept never coincide: a set pending flag means ready is low.
    assign transfer_s  = frame_end_s && pend_flag_r;

    // Refresh prescaler and digit scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else if (presc_tc_s) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Load handshake, pending/active double buffer and sticky BCD error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r    <= {DW{1'b0}};
            pending_r   <= {DW{1'b0}};
            pend_flag_r <= 1'b0;
            ready_r     <= 1'b1;
            bcd_err_r   <= 1'b0;
        end else if (transfer_s) begin
            active_r    <= pending_r;
            pend_flag_r <= 1'b0;
            ready_r     <= 1'b1;
            bcd_err_r   <= word_has_illegal(pending_r);
        end else if (accept_s) begin
            pending_r   <= digits_in;
            pend_flag_r <= 1'b1;
            ready_r     <= 1'b0;
        end
    end

    // Select the scanned nibble and decide whether it is a blanked leading zero.
    always_comb begin
        nibble_s   = 4'd0;
        sel_s      = {NUM_DIGITS{1'b0}};
        nz_above_s = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            sel_s[j]   = (idx_r == IW'(j));
            nibble_s   = nibble_s | (active_r[4*j +: 4] & {4{sel_s[j]}});
            nz_above_s = nz_above_s | ((j >= int'(idx_r)) && (active_r[4*j +: 4] != 4'd0));
        end
        lz_blank_s = (BLANK_LZ != 0) && (idx_r != {IW{1'b0}}) && !nz_above_s;
        if (blank || lz_blank_s) begin
            an_nxt_s  = {NUM_DIGITS{1'b1}};
            seg_nxt_s = 7'b1111111;
        end else begin
            an_nxt_s  = ~sel_s;
            seg_nxt_s = bcd_decode(nibble_s);
        end
    end

    // Registered anode and segment drive; dark while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r  <= {NUM_DIGITS{1'b1}};
            seg_r <= 7'b1111111;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
        end
    end

    assign ready   = ready_r;
    assign bcd_err = bcd_err_r;
    assign an      = an_r;
    assign seg     = seg_r;

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Directed bench for bcd_seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// A table of words with their expected per-digit an/seg patterns and error
// flag is applied through the handshake; hand-written sequences cover reset,
// idle scanning, blank, a load accepted on the frame boundary and async reset.
module tb_bcd_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        bcd_err;

    int total = 0;
    int bad   = 0;

    bcd_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .ready     (ready),
        .digits_in (digits_in),
        .blank     (blank),
        .an        (an),
        .seg       (seg),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        hold;     // keep load high with 16'h9999 while ready=0
        logic [15:0] an_exp;   // digit d expectation at [4d +: 4]
        logic [27:0] seg_exp;  // digit d expectation at [7d +: 7]
        logic        err_exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait on negedges until ready is high; n returns the number of cycles waited.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, (n < 100)}, 32'd1);
    endtask

    // Called at the negedge right after the transfer edge; checks the whole new frame.
    task automatic check_frame(input int v);
        chk("xfer_ready", {31'd0, ready}, 32'd1);
        chk("xfer_err", {31'd0, bcd_err}, {31'd0, vecs[v].err_exp});
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("v%0d_an%0d", v, d), {28'd0, an}, {28'd0, vecs[v].an_exp[4*d +: 4]});
            chk($sformatf("v%0d_seg%0d", v, d), {25'd0, seg}, {25'd0, vecs[v].seg_exp[7*d +: 7]});
            if (d < ND - 1) repeat (RD) @(negedge clk);
        end
    endtask

    // Load a table word through the handshake, wait for the transfer, check the frame.
    task automatic load_word(input int v);
        int n;
        load      = 1'b1;
        digits_in = vecs[v].word;
        @(negedge clk);
        chk("ready_drop", {31'd0, ready}, 32'd0);
        if (vecs[v].hold) digits_in = 16'h9999;
        else load = 1'b0;
        wait_ready(n);
        load = 1'b0;
        check_frame(v);
    endtask

    initial begin
        int n;
        int lit;
        int dark;

        vecs[0] = '{16'h0142, 1'b0, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b1001111, 7'b1001100, 7'b0010010}, 1'b0};
        vecs[1] = '{16'h1234, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 1'b0};
        vecs[2] = '{16'h00A5, 1'b0, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 1'b1};
        vecs[3] = '{16'h0005, 1'b0, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 1'b0};
        vecs[4] = '{16'h9000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0000100, 7'b0000001, 7'b0000001, 7'b0000001}, 1'b0};
        vecs[5] = '{16'h0000, 1'b0, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 1'b0};
        vecs[6] = '{16'h8888, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 1'b0};
        vecs[7] = '{16'h5678, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 1'b0};
        vecs[8] = '{16'hF030, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b0000001, 7'b0000110, 7'b0000001}, 1'b1};

        // Reset state.
        #12;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_err", {31'd0, bcd_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: only digit 0 lit showing "0", 4 of every 16 cycles.
        lit  = 0;
        dark = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && seg == 7'b0000001) lit++;
            if (an == 4'b1111 && seg == 7'b1111111) dark++;
        end
        chk("idle_lit", lit, 32'd4);
        chk("idle_dark", dark, 32'd12);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_err", {31'd0, bcd_err}, 32'd0);

        // Table-driven words, including back-to-back hold and sticky error set/clear.
        for (int v = 0; v < 7; v++) begin
            load_word(v);
        end

        // Blank for 10 cycles during 8888; scanning keeps going underneath.
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("blank_an", {28'd0, an}, 32'hF);
            chk("blank_seg", {25'd0, seg}, 32'h7F);
        end
        blank = 1'b0;
        @(negedge clk);
        chk("unblank_an", {28'd0, an}, 32'hD);
        chk("unblank_seg", {25'd0, seg}, 32'h00);

        // Load accepted exactly on the frame-boundary edge waits a full frame.
        repeat (7) @(negedge clk);
        load      = 1'b1;
        digits_in = vecs[7].word;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk("bnd_old_an", {28'd0, an}, 32'hE);
        chk("bnd_old_seg", {25'd0, seg}, 32'h00);
        wait_ready(n);
        chk("bnd_wait", n, 32'd15);
        check_frame(7);

        // Illegal word sets bcd_err; then reset clears everything asynchronously.
        @(negedge clk);
        load_word(8);
        @(negedge clk);
        load      = 1'b1;
        digits_in = 16'h4321;
        @(negedge clk);
        load = 1'b0;
        chk("pre_rst_ready", {31'd0, ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", {28'd0, an}, 32'hF);
        chk("arst_seg", {25'd0, seg}, 32'h7F);
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_err", {31'd0, bcd_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_an0", {28'd0, an}, 32'hE);
        chk("post_seg0", {25'd0, seg}, 32'h01);
        repeat (4) @(negedge clk);
        chk("post_an1", {28'd0, an}, 32'hF);
        repeat (28) @(negedge clk);
        chk("post_late_an", {28'd0, an}, 32'hE);
        chk("post_late_seg", {25'd0, seg}, 32'h01);
        chk("post_late_ready", {31'd0, ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
